uriscv_bus_arb: RTL and testbench

- Round-robin arbiter sharing the single on-chip memory/peripheral bus port between NUM_M requesters: instruction fetch, load/store unit and debug/DMA.
- Sits between the core-side master ports and the SRAM/PIO slave decode in the top level.
- Supports pipelined requests with in-order responses, up to MAX_OUT outstanding.
- Tracks response ownership with an internal owner FIFO and routes each read response back to its originating master.

---
 rtl/uriscv_bus_arb.sv | 146 ++++++++++++++
 tb/tb_uriscv_bus_arb.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uriscv_bus_arb.sv
// uriscv_bus_arb: round-robin arbiter sharing one pipelined bus port among
// NUM_M masters, with an owner FIFO routing in-order responses back.
// Optional bus lock support is compiled in when ARB_LOCK_EN is defined.
module uriscv_bus_arb #(
    parameter int unsigned NUM_M   = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_M-1:0]      m_req,
    input  logic [NUM_M-1:0]      m_we,
    input  logic [NUM_M*AW-1:0]   m_addr,
    input  logic [NUM_M*DW-1:0]   m_wdata,
    input  logic [NUM_M*DW/8-1:0] m_be,
    input  logic [NUM_M-1:0]      m_lock,
    output logic [NUM_M-1:0]      m_gnt,
    output logic [NUM_M-1:0]      m_rvalid,
    output logic [DW-1:0]         m_rdata,
    output logic                  s_req,
    output logic                  s_we,
    output logic [AW-1:0]         s_addr,
    output logic [DW-1:0]         s_wdata,
    output logic [DW/8-1:0]       s_be,
    input  logic                  s_gnt,
    input  logic                  s_rvalid,
    input  logic [DW-1:0]         s_rdata,
    output logic                  err_o
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned SW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int unsigned PW = $clog2(MAX_OUT);
    localparam int unsigned CW = PW + 1;

    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] rr_sel;
    logic          rr_found;
    logic [SW-1:0] gsel;
    logic          any_req;
    logic [SW-1:0] mux_idx;
    logic          accept;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;

    logic [SW-1:0] owner_q [MAX_OUT];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Round-robin search for the first requester at or after rr_ptr
    always_comb begin
        rr_sel   = '0;
        rr_found = 1'b0;
        for (int unsigned k = 0; k < NUM_M; k++) begin
            int unsigned idx;
            idx = (32'(rr_ptr) + k) % NUM_M;
            if (!rr_found && m_req[SW'(idx)]) begin
                rr_sel   = SW'(idx);
                rr_found = 1'b1;
            end
        end
    end

`ifdef ARB_LOCK_EN
    logic          lock_vld;
    logic [SW-1:0] lock_id;

    // A held lock pins selection to its owner, even while the owner is idle
    always_comb begin
        gsel    = lock_vld ? lock_id : rr_sel;
        any_req = lock_vld ? m_req[lock_id] : rr_found;
    end

    // Lock follows the m_lock bit of every accepted transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_vld <= 1'b0;
            lock_id  <= '0;
        end else if (accept) begin
            lock_vld <= m_lock[gsel];
            lock_id  <= gsel;
        end
    end
`else
    logic lock_unused;

    // Lock inputs have no function in the plain round-robin build
    assign lock_unused = ^m_lock;

    // Plain round-robin selection
    always_comb begin
        gsel    = rr_sel;
        any_req = rr_found;
    end
`endif

    // Request issue, grant, response routing and slave-side mux
    always_comb begin
        fifo_full  = (count == CW'(MAX_OUT));
        fifo_empty = (count == '0);
        s_req      = any_req & ~fifo_full & ~rst;
        accept     = s_req & s_gnt;
        pop        = s_rvalid & ~fifo_empty & ~rst;

        m_gnt = '0;
        if (accept) m_gnt[gsel] = 1'b1;

        m_rvalid = '0;
        if (pop) m_rvalid[owner_q[rd_ptr]] = 1'b1;
        m_rdata = s_rdata;

        mux_idx = any_req ? gsel : '0;
        s_we    = m_we[mux_idx];
        s_addr  = m_addr[32'(mux_idx) * AW +: AW];
        s_wdata = m_wdata[32'(mux_idx) * DW +: DW];
        s_be    = m_be[32'(mux_idx) * BW +: BW];
    end

    // Owner storage: one entry per accepted transfer
    always_ff @(posedge clk) begin
        if (accept) owner_q[wr_ptr] <= gsel;
    end

    // Pointers, occupancy, fairness pointer and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_o  <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (gsel == SW'(NUM_M - 1)) ? '0 : gsel + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(accept) - CW'(pop);
            if (s_rvalid && fifo_empty) err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uriscv_bus_arb.sv
// Self-checking bench for uriscv_bus_arb: directed vector table, corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_uriscv_bus_arb;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NM-1:0]     m_req, m_we, m_lock, m_gnt, m_rvalid;
    logic [NM*AW-1:0]  m_addr;
    logic [NM*DW-1:0]  m_wdata;
    logic [NM*BW-1:0]  m_be;
    logic [DW-1:0]     m_rdata;
    logic              s_req, s_we, s_gnt, s_rvalid, err_o;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata, s_rdata;
    logic [BW-1:0]     s_be;

    logic [AW-1:0] addr_a  [NM];
    logic [DW-1:0] wdata_a [NM];
    logic [BW-1:0] be_a    [NM];

    always #5 clk = ~clk;

    // Pack per-master payloads onto the flat ports
    always_comb begin
        for (int i = 0; i < NM; i++) begin
            m_addr[i*AW +: AW]  = addr_a[i];
            m_wdata[i*DW +: DW] = wdata_a[i];
            m_be[i*BW +: BW]    = be_a[i];
        end
    end

    uriscv_bus_arb #(.NUM_M(NM), .AW(AW), .DW(DW), .MAX_OUT(MO)) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_be(m_be), .m_lock(m_lock),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_be(s_be), .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .err_o(err_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: owner queue, round-robin pointer, sticky error bit
    int      md_rr;
    int      md_q[$];
    bit      md_err;
    int      e_sel, e_mux;
    bit      e_found, e_sreq, e_acc, e_pop;
    logic [NM-1:0] e_gnt, e_rv;

    task automatic model_comb();
        e_found = 1'b0;
        e_sel   = 0;
        for (int k = 0; k < NM; k++) begin
            int i;
            i = (md_rr + k) % NM;
            if (!e_found && m_req[i]) begin
                e_sel   = i;
                e_found = 1'b1;
            end
        end
        e_sreq = e_found && (md_q.size() < MO) && !rst;
        e_acc  = e_sreq && s_gnt;
        e_gnt  = '0;
        if (e_acc) e_gnt[e_sel] = 1'b1;
        e_pop  = s_rvalid && (md_q.size() > 0) && !rst;
        e_rv   = '0;
        if (e_pop) e_rv[md_q[0]] = 1'b1;
        e_mux  = e_found ? e_sel : 0;
    endtask

    // Clock edge: update model with the inputs that were just sampled
    task automatic advance();
        @(posedge clk);
        model_comb();
        if (rst) begin
            md_rr  = 0;
            md_q.delete();
            md_err = 1'b0;
        end else begin
            if (s_rvalid && md_q.size() == 0) md_err = 1'b1;
            if (e_pop) void'(md_q.pop_front());
            if (e_acc) begin
                md_q.push_back(e_sel);
                md_rr = (e_sel + 1) % NM;
            end
        end
        #1;
    endtask

    task automatic check_model();
        model_comb();
        chk("m_gnt",    64'(m_gnt),    64'(e_gnt));
        chk("m_rvalid", 64'(m_rvalid), 64'(e_rv));
        chk("s_req",    64'(s_req),    64'(e_sreq));
        chk("s_addr",   64'(s_addr),   64'(addr_a[e_mux]));
        chk("s_we",     64'(s_we),     64'(m_we[e_mux]));
        chk("s_wdata",  64'(s_wdata),  64'(wdata_a[e_mux]));
        chk("s_be",     64'(s_be),     64'(be_a[e_mux]));
        chk("m_rdata",  64'(m_rdata),  64'(s_rdata));
        chk("err_o",    64'(err_o),    64'(md_err));
    endtask

    task automatic do_reset();
        rst = 1'b1; m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0; m_lock = '0;
        advance();
        advance();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [NM-1:0] req;
        logic          gnt;
        logic          rv;
        logic [NM-1:0] e_gnt;
        logic [NM-1:0] e_rv;
        logic          e_sreq;
        logic          e_err;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t tbl[16];
    int   gcount;
    bit   pend[NM];

    initial begin
        tbl[0]  = '{2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 32'h100};
        tbl[1]  = '{2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 32'h100};
        tbl[2]  = '{2'b11, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 32'h200};
        tbl[3]  = '{2'b11, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 32'h100};
        tbl[4]  = '{2'b11, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 32'h200};
        tbl[5]  = '{2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 32'h100};
        tbl[6]  = '{2'b11, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 32'h100};
        tbl[7]  = '{2'b10, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 32'h200};
        tbl[8]  = '{2'b11, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 32'h100};
        tbl[9]  = '{2'b11, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 32'h100};
        tbl[10] = '{2'b00, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 32'h100};
        tbl[11] = '{2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 32'h100};
        tbl[12] = '{2'b00, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 32'h100};
        tbl[13] = '{2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 32'h100};
        tbl[14] = '{2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 32'h100};
        tbl[15] = '{2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 32'h100};

        md_rr = 0; md_err = 1'b0;
        m_we = 2'b10; s_rdata = 32'hDEAD_BEEF;
        addr_a[0] = 32'h100; addr_a[1] = 32'h200;
        wdata_a[0] = 32'h1111_1111; wdata_a[1] = 32'h2222_2222;
        be_a[0] = 4'hF; be_a[1] = 4'h3;

        // Reset forces request/grant/response outputs low
        rst = 1'b1; m_req = 2'b11; s_gnt = 1'b1; s_rvalid = 1'b1; m_lock = '0;
        @(negedge clk);
        chk("rst_s_req", 64'(s_req), 64'd0);
        chk("rst_m_gnt", 64'(m_gnt), 64'd0);
        chk("rst_m_rvalid", 64'(m_rvalid), 64'd0);
        advance();
        do_reset();
        chk("rst_err_o", 64'(err_o), 64'd0);

        // Directed vector table
        for (int v = 0; v < 16; v++) begin
            m_req = tbl[v].req; s_gnt = tbl[v].gnt; s_rvalid = tbl[v].rv;
            s_rdata = 32'hA000_0000 + 32'(v);
            @(negedge clk);
            chk($sformatf("vec%0d_m_gnt", v),    64'(m_gnt),    64'(tbl[v].e_gnt));
            chk($sformatf("vec%0d_m_rvalid", v), 64'(m_rvalid), 64'(tbl[v].e_rv));
            chk($sformatf("vec%0d_s_req", v),    64'(s_req),    64'(tbl[v].e_sreq));
            chk($sformatf("vec%0d_err_o", v),    64'(err_o),    64'(tbl[v].e_err));
            chk($sformatf("vec%0d_s_addr", v),   64'(s_addr),   64'(tbl[v].e_addr));
            chk($sformatf("vec%0d_m_rdata", v),  64'(m_rdata),  64'(s_rdata));
            advance();
        end
        chk("err_sticky", 64'(err_o), 64'd1);

        // Backpressure: exactly MAX_OUT grants, one response reopens issue
        do_reset();
        gcount = 0;
        m_req = 2'b11; s_gnt = 1'b1; s_rvalid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            gcount += $countones(m_gnt);
            if (c == 9) chk("bp_s_req_full", 64'(s_req), 64'd0);
            advance();
        end
        chk("bp_grants", 64'(gcount), 64'(MO));
        s_rvalid = 1'b1;
        @(negedge clk);
        chk("bp_pop_s_req", 64'(s_req), 64'd0);
        chk("bp_pop_rvalid", 64'(m_rvalid), 64'b01);
        advance();
        s_rvalid = 1'b0;
        @(negedge clk);
        chk("bp_reissue", 64'(s_req), 64'd1);
        advance();

        // Spurious response, then reset with three outstanding
        do_reset();
        m_req = 2'b00; s_rvalid = 1'b1;
        @(negedge clk);
        chk("spur_rvalid", 64'(m_rvalid), 64'd0);
        advance();
        s_rvalid = 1'b0; m_req = 2'b11; s_gnt = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("spur_err_held", 64'(err_o), 64'd1);
            advance();
        end
        rst = 1'b1; s_rvalid = 1'b1;
        @(negedge clk);
        chk("midrst_s_req", 64'(s_req), 64'd0);
        chk("midrst_m_gnt", 64'(m_gnt), 64'd0);
        chk("midrst_rvalid", 64'(m_rvalid), 64'd0);
        advance();
        rst = 1'b0; m_req = 2'b00; s_rvalid = 1'b1;
        @(negedge clk);
        chk("postrst_err", 64'(err_o), 64'd0);
        chk("postrst_empty", 64'(m_rvalid), 64'd0);
        advance();
        m_req = 2'b11; s_rvalid = 1'b0;
        @(negedge clk);
        chk("postrst_rr0", 64'(m_gnt), 64'b01);
        chk("postrst_err_set", 64'(err_o), 64'd1);
        advance();

`ifdef ARB_LOCK_EN
        // Lock: master 1 holds the bus until it issues an unlocked transfer
        do_reset();
        s_gnt = 1'b1; s_rvalid = 1'b0;
        m_req = 2'b10; m_lock = 2'b10;
        @(negedge clk);
        chk("lock_take", 64'(m_gnt), 64'b10);
        advance();
        m_req = 2'b01;
        @(negedge clk);
        chk("lock_block", 64'(m_gnt), 64'b00);
        advance();
        m_req = 2'b11; m_lock = 2'b00;
        @(negedge clk);
        chk("lock_release", 64'(m_gnt), 64'b10);
        advance();
        m_req = 2'b01;
        @(negedge clk);
        chk("lock_after", 64'(m_gnt), 64'b01);
        advance();
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < NM; i++) pend[i] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NM; i++) begin
                if (!pend[i] && ($urandom % 10) < 4) begin
                    pend[i]    = 1'b1;
                    addr_a[i]  = $urandom;
                    wdata_a[i] = $urandom;
                    be_a[i]    = BW'($urandom);
                    m_we[i]    = 1'($urandom);
                end
                m_req[i] = pend[i];
            end
`ifdef ARB_LOCK_EN
            m_lock = '0;
`else
            m_lock = NM'($urandom);
`endif
            s_gnt    = (($urandom % 10) < 7);
            s_rvalid = (md_q.size() > 0) ? (($urandom % 2) == 0) : (($urandom % 50) == 0);
            s_rdata  = $urandom;
            rst      = (($urandom % 300) == 0);
            @(negedge clk);
            check_model();
            for (int i = 0; i < NM; i++) if (e_gnt[i]) pend[i] = 1'b0;
            advance();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
